// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 5x4 keypad, debounces press/release and emits one-cycle key strobes.
// Optional auto-repeat of a held key (REPEAT state) is compiled in with `define KEY_REPEAT_EN.
`timescale 1ns/1ps
module keypad_encoder #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 50000,
  parameter int unsigned REPEAT_DELAY = 25000000,
  parameter int unsigned REPEAT_RATE  = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  output logic [4:0] row_drive,
  input  logic [3:0] col_sense,
  output logic       dig_in,
  output logic       op_in,
  output logic       sub_in,
  output logic       ex_in,
  output logic       bksp_in,
  output logic       reset_in,
  output logic       MS_in,
  output logic       MR_in,
  output logic       MC_in,
  output logic [3:0] digit,
  output logic [1:0] op_code,
  output logic [4:0] key_code
);

  localparam int unsigned NUM_ROWS = 5;
  localparam int unsigned MAX_A    = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int unsigned MAX_B    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  localparam int unsigned NUM_ST  = 9;
  localparam int unsigned ST_DIG  = 8;
  localparam int unsigned ST_OP   = 7;
  localparam int unsigned ST_SUB  = 6;
  localparam int unsigned ST_EX   = 5;
  localparam int unsigned ST_BKSP = 4;
  localparam int unsigned ST_CLR  = 3;
  localparam int unsigned ST_MS   = 2;
  localparam int unsigned ST_MR   = 1;
  localparam int unsigned ST_MC   = 0;

  typedef enum logic [2:0] {
    SCAN,
    DEB_PRESS,
    EMIT,
    HOLD,
    DEB_REL
`ifdef KEY_REPEAT_EN
    , REPEAT
`endif
  } state_t;

  state_t              state;
  logic [3:0]          col_meta;
  logic [3:0]          col_sync;
  logic [2:0]          row;
  logic [1:0]          col;
  logic [CW-1:0]       div_cnt;
  logic [CW-1:0]       deb_cnt;
  logic [NUM_ST-1:0]   strobe_q;

  logic                any_low_c;
  logic                all_high_c;
  logic [1:0]          low_col_c;
  logic [2:0]          next_row_c;
  logic [4:0]          key_idx_c;
  logic [NUM_ST-1:0]   decode_c;
  logic [3:0]          digit_c;
  logic [1:0]          op_c;

`ifdef KEY_REPEAT_EN
  localparam logic [4:0] KEY_C = 5'd16;
  logic [CW-1:0] rep_cnt;
  logic          rep_first;
  logic [CW-1:0] rep_target_c;
  assign rep_target_c = rep_first ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_RATE - 1);
`endif

  function automatic logic [4:0] row_sel(input logic [2:0] r);
    row_sel = ~(5'b00001 << r);
  endfunction

  assign all_high_c = &col_sync;
  assign any_low_c  = ~all_high_c;
  assign next_row_c = (row == 3'(NUM_ROWS - 1)) ? 3'd0 : row + 3'd1;
  assign key_idx_c  = {row, col};

  // Lowest-index low column wins when several keys in the row are down.
  always_comb begin
    low_col_c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_sync[i]) low_col_c = 2'(i);
    end
  end

  always_comb begin
    decode_c = '0;
    digit_c  = '0;
    op_c     = '0;
    case (key_idx_c)
      5'd0:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd1; end
      5'd1:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd2; end
      5'd2:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd3; end
      5'd3:  begin decode_c[ST_OP]  = 1'b1; op_c    = 2'd0; end
      5'd4:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd4; end
      5'd5:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd5; end
      5'd6:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd6; end
      5'd7:  begin decode_c[ST_OP]  = 1'b1; decode_c[ST_SUB] = 1'b1; op_c = 2'd1; end
      5'd8:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd7; end
      5'd9:  begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd8; end
      5'd10: begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd9; end
      5'd11: begin decode_c[ST_OP]  = 1'b1; op_c    = 2'd2; end
      5'd12: decode_c[ST_MR] = 1'b1;
      5'd13: begin decode_c[ST_DIG] = 1'b1; digit_c = 4'd0; end
      5'd14: decode_c[ST_EX] = 1'b1;
      5'd15: begin decode_c[ST_OP]  = 1'b1; op_c    = 2'd3; end
      5'd16: decode_c[ST_CLR]  = 1'b1;
      5'd17: decode_c[ST_BKSP] = 1'b1;
      5'd18: decode_c[ST_MS]   = 1'b1;
      5'd19: decode_c[ST_MC]   = 1'b1;
      default: ;
    endcase
  end

  // Synchronizer resets to the released (all-high) level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_meta  <= '1;
      col_sync  <= '1;
      state     <= SCAN;
      row       <= '0;
      col       <= '0;
      row_drive <= 5'b11110;
      div_cnt   <= '0;
      deb_cnt   <= '0;
      strobe_q  <= '0;
      digit     <= '0;
      op_code   <= '0;
      key_code  <= '0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b0;
`endif
    end else begin
      col_meta <= col_sense;
      col_sync <= col_meta;
      strobe_q <= '0;
      case (state)
        SCAN: begin
          if (div_cnt == CW'(SCAN_DIV - 1)) begin
            div_cnt <= '0;
            if (any_low_c) begin
              col     <= low_col_c;
              deb_cnt <= '0;
              state   <= DEB_PRESS;
            end else begin
              row       <= next_row_c;
              row_drive <= row_sel(next_row_c);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (col_sync[col]) begin
            state     <= SCAN;
            div_cnt   <= '0;
            row       <= next_row_c;
            row_drive <= row_sel(next_row_c);
          end else if (deb_cnt == CW'(DEBOUNCE_CNT)) begin
            state    <= EMIT;
            strobe_q <= decode_c;
            key_code <= key_idx_c;
            if (decode_c[ST_DIG]) digit   <= digit_c;
            if (decode_c[ST_OP])  op_code <= op_c;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        EMIT: begin
          state <= HOLD;
`ifdef KEY_REPEAT_EN
          rep_cnt   <= CW'(1);
          rep_first <= 1'b1;
`endif
        end
        HOLD: begin
          if (all_high_c) begin
            state   <= DEB_REL;
            deb_cnt <= '0;
`ifdef KEY_REPEAT_EN
          end else if (key_idx_c != KEY_C && rep_cnt == rep_target_c) begin
            state    <= REPEAT;
            strobe_q <= decode_c;
          end else if (rep_cnt != '1) begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end
        DEB_REL: begin
          if (any_low_c) begin
            state <= HOLD;
          end else if (deb_cnt == CW'(DEBOUNCE_CNT)) begin
            state     <= SCAN;
            div_cnt   <= '0;
            row       <= next_row_c;
            row_drive <= row_sel(next_row_c);
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
`ifdef KEY_REPEAT_EN
        REPEAT: begin
          state     <= HOLD;
          rep_cnt   <= CW'(1);
          rep_first <= 1'b0;
        end
`endif
        default: state <= SCAN;
      endcase
    end
  end

  assign dig_in   = strobe_q[ST_DIG];
  assign op_in    = strobe_q[ST_OP];
  assign sub_in   = strobe_q[ST_SUB];
  assign ex_in    = strobe_q[ST_EX];
  assign bksp_in  = strobe_q[ST_BKSP];
  assign reset_in = strobe_q[ST_CLR];
  assign MS_in    = strobe_q[ST_MS];
  assign MR_in    = strobe_q[ST_MR];
  assign MC_in    = strobe_q[ST_MC];

endmodule

// File: tb/tb_keypad_encoder.sv
// Randomized and directed bench for keypad_encoder against a key-map reference model.
`timescale 1ns/1ps
module tb_keypad_encoder;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int RDLY     = 20;
  localparam int RRATE    = 10;
`ifdef KEY_REPEAT_EN
  localparam int MAX_HOLD = 12;
`else
  localparam int MAX_HOLD = 1000;
`endif
  localparam int EV_BUDGET = 10 * SCAN_DIV + DEB + 10;
  localparam int SETTLE    = 3 * DEB + 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] row_drive;
  logic [3:0] col_sense;
  logic       dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in;
  logic [3:0] digit;
  logic [1:0] op_code;
  logic [4:0] key_code;
  logic [8:0] strobes;

  logic [3:0] pressed [5];
  int         cyc;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  s;
    logic [3:0]  d;
    logic [1:0]  op;
    logic [4:0]  kc;
  } ev_t;
  ev_t evq[$];

  string keymap [20] = '{"1", "2", "3", "+", "4", "5", "6", "-", "7", "8", "9", "*",
                         "MR", "0", "=", "/", "C", "BKSP", "MS", "MC"};

  keypad_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clock(clock), .reset(reset), .row_drive(row_drive), .col_sense(col_sense),
    .dig_in(dig_in), .op_in(op_in), .sub_in(sub_in), .ex_in(ex_in), .bksp_in(bksp_in),
    .reset_in(reset_in), .MS_in(MS_in), .MR_in(MR_in), .MC_in(MC_in),
    .digit(digit), .op_code(op_code), .key_code(key_code)
  );

  always #5 clock = ~clock;

  assign strobes = {dig_in, op_in, sub_in, ex_in, bksp_in, reset_in, MS_in, MR_in, MC_in};

  // Passive key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_sense = 4'hF;
    for (int r = 0; r < 5; r++) begin
      if (!row_drive[r]) col_sense = col_sense & ~pressed[r];
    end
  end

  // Cycle n is the clock period ending at the n-th rising edge after reset release.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (!reset && strobes != 9'd0)
      evq.push_back('{cyc: 32'(cyc), s: strobes, d: digit, op: op_code, kc: key_code});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe vector order: dig, op, sub, ex, bksp, reset, MS, MR, MC.
  task automatic model_key(input int r, input int c, output logic [8:0] s,
                           output logic [3:0] d, output logic [1:0] op);
    string      k;
    logic [7:0] ch;
    k  = keymap[r * 4 + c];
    ch = k.getc(0);
    s  = '0;
    d  = '0;
    op = '0;
    if (k.len() == 1 && ch >= 8'h30 && ch <= 8'h39) begin
      s[8] = 1'b1;
      d    = 4'(ch - 8'h30);
    end
    else if (k == "+")    begin s[7] = 1'b1; op = 2'd0; end
    else if (k == "-")    begin s[7] = 1'b1; s[6] = 1'b1; op = 2'd1; end
    else if (k == "*")    begin s[7] = 1'b1; op = 2'd2; end
    else if (k == "/")    begin s[7] = 1'b1; op = 2'd3; end
    else if (k == "=")    s[5] = 1'b1;
    else if (k == "BKSP") s[4] = 1'b1;
    else if (k == "C")    s[3] = 1'b1;
    else if (k == "MS")   s[2] = 1'b1;
    else if (k == "MR")   s[1] = 1'b1;
    else if (k == "MC")   s[0] = 1'b1;
  endtask

  task automatic release_all();
    for (int r = 0; r < 5; r++) pressed[r] = 4'h0;
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 10000 && cyc < c; i++) @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  // One press (optionally a second same-row key at the same time, and a stray key during hold).
  task automatic run_press(input string tag, input int r, input int c, input int r2, input int c2,
                           input int hold, input bit extra);
    logic [8:0] es;
    logic [3:0] ed;
    logic [1:0] eop;
    int         wc;
    int         p;
    int         h;
    wc = (r2 == r && c2 < c) ? c2 : c;
    model_key(r, wc, es, ed, eop);
    h = (hold > MAX_HOLD) ? MAX_HOLD : hold;
    evq.delete();
    @(negedge clock);
    pressed[r][c] = 1'b1;
    if (r2 >= 0) pressed[r2][c2] = 1'b1;
    p = cyc;
    for (int i = 0; i < EV_BUDGET && evq.size() == 0; i++) @(negedge clock);
    if (extra) pressed[$urandom_range(4, 0)][$urandom_range(3, 0)] = 1'b1;
    repeat (h) @(negedge clock);
    release_all();
    repeat (SETTLE) @(negedge clock);
    check_eq({tag, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      check_eq({tag, "_strobes"}, evq[0].s, es);
      check_eq({tag, "_key_code"}, evq[0].kc, r * 4 + wc);
      if (es[8]) check_eq({tag, "_digit"}, evq[0].d, ed);
      if (es[7]) check_eq({tag, "_op_code"}, evq[0].op, eop);
      check_eq({tag, "_latency"},
               (evq[0].cyc >= p + DEB + 4) && (evq[0].cyc <= p + DEB + 3 + 5 * SCAN_DIV), 1);
    end
    check_eq({tag, "_kc_hold"}, key_code, r * 4 + wc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bounce_det;
    int redet;
    int e0;
    release_all();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_row_drive", row_drive, 5'b11110);
    check_eq("rst_strobes", strobes, 0);
    check_eq("rst_digit", digit, 0);
    check_eq("rst_op_code", op_code, 0);
    check_eq("rst_key_code", key_code, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    run_press("eight", 2, 1, -1, -1, 40, 1'b0);
    run_press("minus", 1, 3, -1, -1, 10, 1'b0);
    run_press("clr_ms", 4, 0, 4, 2, 10, 1'b0);
    run_press("ms", 4, 2, -1, -1, 10, 1'b0);

    for (int n = 0; n < 12; n++) begin
      int r, c, r2, c2;
      r = $urandom_range(4, 0);
      c = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1) begin r2 = r; c2 = $urandom_range(3, 0); end
      else begin r2 = -1; c2 = -1; end
      run_press($sformatf("rnd%0d", n), r, c, r2, c2, $urandom_range(30, 2),
                1'($urandom_range(1, 0)));
    end

    // Bounce on '=': first detection at the row3 sample edge, aborted by the high cycle,
    // re-detected one full scan after the abort; strobe registered DEB+1 edges later.
    bounce_det = 4 * SCAN_DIV - 1;
    redet      = bounce_det + 3 + 5 * SCAN_DIV;
    release_all();
    apply_reset();
    evq.delete();
    wait_until(bounce_det - 4);
    pressed[3][2] = 1'b1;
    wait_until(bounce_det + 1);
    pressed[3][2] = 1'b0;
    wait_until(bounce_det + 2);
    pressed[3][2] = 1'b1;
    wait_until(redet + 22);
    release_all();
    repeat (SETTLE) @(negedge clock);
    check_eq("bounce_count", evq.size(), 1);
    if (evq.size() > 0) begin
      check_eq("bounce_strobes", evq[0].s, 9'b000100000);
      check_eq("bounce_cycle", evq[0].cyc, redet + DEB + 2);
      check_eq("bounce_key_code", evq[0].kc, 14);
    end

    // Reset in the middle of the debounce of key '1'; the still-held key is found again.
    evq.delete();
    @(negedge clock);
    reset = 1'b1;
    pressed[0][0] = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_until(SCAN_DIV + 4);
    check_eq("rstmid_pre_count", evq.size(), 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("rstmid_row_drive", row_drive, 5'b11110);
      check_eq("rstmid_strobes", strobes, 0);
    end
    reset = 1'b0;
    for (int i = 0; i < EV_BUDGET && evq.size() == 0; i++) @(negedge clock);
    repeat (5) @(negedge clock);
    release_all();
    repeat (SETTLE) @(negedge clock);
    check_eq("rstmid_count", evq.size(), 1);
    if (evq.size() > 0) begin
      check_eq("rstmid_strobes", evq[0].s, 9'b100000000);
      check_eq("rstmid_digit", evq[0].d, 1);
      check_eq("rstmid_cycle", evq[0].cyc, SCAN_DIV - 1 + DEB + 2);
    end

`ifdef KEY_REPEAT_EN
    evq.delete();
    @(negedge clock);
    pressed[4][1] = 1'b1;
    for (int i = 0; i < EV_BUDGET && evq.size() == 0; i++) @(negedge clock);
    e0 = (evq.size() > 0) ? int'(evq[0].cyc) : cyc;
    wait_until(e0 + 52);
    release_all();
    repeat (SETTLE) @(negedge clock);
    check_eq("rep_count", evq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < evq.size()) begin
        check_eq($sformatf("rep_cycle%0d", i), evq[i].cyc,
                 e0 + ((i == 0) ? 0 : RDLY + (i - 1) * RRATE));
        check_eq($sformatf("rep_strobes%0d", i), evq[i].s, 9'b000010000);
      end
    end
`else
    e0 = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
